// File: rtl/vend_request_arbiter_pkg.sv
// rtl/vend_request_arbiter_pkg.sv - state encodings, coin values and widths shared by the vend arbiter
package vend_request_arbiter_pkg;

   localparam int MONEY_W = 7;
   localparam int CNT_W   = 4;

   localparam int COIN_Q = 25;
   localparam int COIN_D = 10;
   localparam int COIN_N = 5;
   localparam int COIN_P = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_REJECT = 3'd4,
      ST_ABORT  = 3'd5
   } vend_state_t;

   // Coin counters stick at all-ones rather than wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
      return (hit && (c != '1)) ? c + 1'b1 : c;
   endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// rtl/vend_rr_arbiter.sv - combinational round-robin pick; the pointer register lives in the parent
module vend_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      // Scan from the far end so the nearest request at or after ptr wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NREQ]) begin
            gnt = '0;
            gnt[(int'(ptr) + k) % NREQ] = 1'b1;
            idx = IDW'((int'(ptr) + k) % NREQ);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vend_request_arbiter.sv
// rtl/vend_request_arbiter.sv - shares one vending change dispenser between NREQ ports
// VEND_TIMEOUT_EN adds a WAIT-state timeout that aborts the transaction and resets the vending FSM.
module vend_request_arbiter
   import vend_request_arbiter_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int IDW         = 2,
   parameter int START_LEN   = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [MONEY_W*NREQ-1:0] req_money,
   input  logic [MONEY_W*NREQ-1:0] req_price,
   output logic [NREQ-1:0]         ack,
   output logic                    err,
   output logic                    busy,
   output logic [IDW-1:0]          gnt_id,
   output logic [CNT_W-1:0]        chg_q,
   output logic [CNT_W-1:0]        chg_d,
   output logic [CNT_W-1:0]        chg_n,
   output logic [CNT_W-1:0]        chg_p,
   output logic [MONEY_W-1:0]      fsm_money,
   output logic [MONEY_W-1:0]      fsm_price,
   output logic                    fsm_start,
   output logic                    fsm_reset,
   input  logic                    fsm_done,
   input  logic                    fsm_disp_q,
   input  logic                    fsm_disp_d,
   input  logic                    fsm_disp_n,
   input  logic                    fsm_disp_p
);

   // One cycle counter serves both the start pulse and the WAIT timeout.
   localparam int CYC_MAX = (START_LEN > TIMEOUT_CYC) ? START_LEN : TIMEOUT_CYC;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);

   vend_state_t          state;
   logic [IDW-1:0]       ptr;
   logic [NREQ-1:0]      gnt_oh;
   logic [CYC_W-1:0]     cyc;
   logic [NREQ-1:0]      rr_gnt;
   logic [IDW-1:0]       rr_idx;
   logic                 rr_any;
   logic [MONEY_W-1:0]   sel_money;
   logic [MONEY_W-1:0]   sel_price;

   vend_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req (req),
      .ptr (ptr),
      .gnt (rr_gnt),
      .idx (rr_idx),
      .any (rr_any)
   );

   assign sel_money = req_money[MONEY_W*rr_idx +: MONEY_W];
   assign sel_price = req_price[MONEY_W*rr_idx +: MONEY_W];

`ifdef VEND_TIMEOUT_EN
   logic abort_q;
   assign fsm_reset = ~reset | abort_q;
`else
   assign fsm_reset = ~reset;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         ack       <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         fsm_start <= 1'b0;
         gnt_id    <= '0;
         gnt_oh    <= '0;
         ptr       <= '0;
         cyc       <= '0;
         chg_q     <= '0;
         chg_d     <= '0;
         chg_n     <= '0;
         chg_p     <= '0;
         fsm_money <= '0;
         fsm_price <= '0;
`ifdef VEND_TIMEOUT_EN
         abort_q   <= 1'b0;
`endif
      end else begin
         ack <= '0;
         err <= 1'b0;
`ifdef VEND_TIMEOUT_EN
         abort_q <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (rr_any) begin
                  gnt_id    <= rr_idx;
                  gnt_oh    <= rr_gnt;
                  fsm_money <= sel_money;
                  fsm_price <= sel_price;
                  chg_q     <= '0;
                  chg_d     <= '0;
                  chg_n     <= '0;
                  chg_p     <= '0;
                  ptr       <= (rr_idx == IDW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
                  busy      <= 1'b1;
                  cyc       <= '0;
                  if (sel_money < sel_price) begin
                     state <= ST_REJECT;
                     ack   <= rr_gnt;
                     err   <= 1'b1;
                  end else begin
                     state     <= ST_START;
                     fsm_start <= 1'b1;
                  end
               end
            end
            ST_START, ST_WAIT: begin
               chg_q <= sat_inc(chg_q, fsm_disp_q);
               chg_d <= sat_inc(chg_d, fsm_disp_d);
               chg_n <= sat_inc(chg_n, fsm_disp_n);
               chg_p <= sat_inc(chg_p, fsm_disp_p);
               if (state == ST_START) begin
                  if (cyc == CYC_W'(START_LEN - 1)) begin
                     fsm_start <= 1'b0;
                     state     <= ST_WAIT;
                     cyc       <= '0;
                  end else begin
                     cyc <= cyc + 1'b1;
                  end
               end else if (fsm_done) begin
                  state <= ST_DONE;
                  ack   <= gnt_oh;
`ifdef VEND_TIMEOUT_EN
               end else if (cyc == CYC_W'(TIMEOUT_CYC - 1)) begin
                  state   <= ST_ABORT;
                  ack     <= gnt_oh;
                  err     <= 1'b1;
                  abort_q <= 1'b1;
`endif
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            ST_DONE, ST_REJECT, ST_ABORT: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_request_arbiter.sv
// tb/tb_vend_request_arbiter.sv - scoreboard bench with a mock vending FSM for vend_request_arbiter
module tb_vend_request_arbiter;
   import vend_request_arbiter_pkg::*;

   localparam int NREQ = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [27:0] req_money;
   logic [27:0] req_price;
   logic [3:0]  ack;
   logic        err;
   logic        busy;
   logic [1:0]  gnt_id;
   logic [3:0]  chg_q, chg_d, chg_n, chg_p;
   logic [6:0]  fsm_money, fsm_price;
   logic        fsm_start, fsm_reset;
   logic        fsm_done, fsm_disp_q, fsm_disp_d, fsm_disp_n, fsm_disp_p;

   typedef struct {
      int port;
      int err;
      int q;
      int d;
      int n;
      int p;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ptr_model = 0;
   int   exp_starts = 0;
   int   seen_starts = 0;
   int   last_start_len = 0;
   bit   mock_en = 1'b1;
   bit   penny_mode = 1'b0;
   logic [6:0] bm [4];
   logic [6:0] bp [4];

   vend_request_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_money  (req_money),
      .req_price  (req_price),
      .ack        (ack),
      .err        (err),
      .busy       (busy),
      .gnt_id     (gnt_id),
      .chg_q      (chg_q),
      .chg_d      (chg_d),
      .chg_n      (chg_n),
      .chg_p      (chg_p),
      .fsm_money  (fsm_money),
      .fsm_price  (fsm_price),
      .fsm_start  (fsm_start),
      .fsm_reset  (fsm_reset),
      .fsm_done   (fsm_done),
      .fsm_disp_q (fsm_disp_q),
      .fsm_disp_d (fsm_disp_d),
      .fsm_disp_n (fsm_disp_n),
      .fsm_disp_p (fsm_disp_p)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, expv);
      end
   endtask

   function automatic void greedy(input int cents, output int q, output int d, output int n, output int p);
      int c;
      c = cents;
      q = c / COIN_Q;  c = c % COIN_Q;
      d = c / COIN_D;  c = c % COIN_D;
      n = c / COIN_N;  c = c % COIN_N;
      p = c / COIN_P;
   endfunction

   // Mock vending FSM: pays out money-price as coin pulses after the start pulse, then done.
   initial begin
      fsm_done = 1'b0; fsm_disp_q = 1'b0; fsm_disp_d = 1'b0; fsm_disp_n = 1'b0; fsm_disp_p = 1'b0;
      forever begin
         @(negedge clk);
         if (mock_en && reset && fsm_start) begin
            int len, c, nq, nd, nn, np;
            logic [6:0] m, p;
            m = fsm_money;
            p = fsm_price;
            len = 0;
            while (fsm_start && len < 16) begin
               len++;
               @(negedge clk);
            end
            last_start_len = len;
            seen_starts++;
            c = int'(m) - int'(p);
            if (c < 0) c = 0;
            if (penny_mode) begin
               nq = 0; nd = 0; nn = 0; np = c;
            end else begin
               greedy(c, nq, nd, nn, np);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int t = 0; t < nq + nd + nn + np; t++) begin
               fsm_disp_q = (t < nq);
               fsm_disp_d = (t >= nq) && (t < nq + nd);
               fsm_disp_n = (t >= nq + nd) && (t < nq + nd + nn);
               fsm_disp_p = (t >= nq + nd + nn);
               @(negedge clk);
               fsm_disp_q = 1'b0; fsm_disp_d = 1'b0; fsm_disp_n = 1'b0; fsm_disp_p = 1'b0;
               repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            fsm_done = 1'b1;
            @(negedge clk);
            fsm_done = 1'b0;
         end
      end
   end

   // Monitor: every ack pops the oldest expected transaction.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && (ack != 4'b0000)) begin
            exp_t e;
            if (exp_q.size() == 0) begin
               check("unexpected_ack", int'(ack), 0);
            end else begin
               e = exp_q.pop_front();
               check("ack_port", int'(ack), 1 << e.port);
               check("err", int'(err), e.err);
               check("gnt_id", int'(gnt_id), e.port);
               check("busy_at_ack", int'(busy), 1);
               check("chg_q", int'(chg_q), e.q);
               check("chg_d", int'(chg_d), e.d);
               check("chg_n", int'(chg_n), e.n);
               check("chg_p", int'(chg_p), e.p);
               if (e.err == 0) check("start_len", last_start_len, 2);
            end
         end
      end
   end

   // Reference: pending ports are served in cyclic order from the pointer; each grant moves it past the winner.
   task automatic run_batch(input logic [3:0] mask);
      int   port, last, budget, c;
      exp_t e;
      last = ptr_model - 1;
      for (int k = 0; k < NREQ; k++) begin
         port = (ptr_model + k) % NREQ;
         if (mask[port]) begin
            e.port = port;
            e.err  = (bm[port] < bp[port]) ? 1 : 0;
            c = (e.err != 0) ? 0 : int'(bm[port]) - int'(bp[port]);
            if (e.err != 0) begin
               e.q = 0; e.d = 0; e.n = 0; e.p = 0;
            end else if (penny_mode) begin
               e.q = 0; e.d = 0; e.n = 0; e.p = (c > 15) ? 15 : c;
               exp_starts++;
            end else begin
               greedy(c, e.q, e.d, e.n, e.p);
               exp_starts++;
            end
            exp_q.push_back(e);
            last = port;
         end
      end
      ptr_model = (last + 1) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
         req_money[7*i +: 7] = bm[i];
         req_price[7*i +: 7] = bp[i];
      end
      req = mask;
      budget = 3000;
      while (budget > 0) begin
         @(negedge clk);
         req = req & ~ack;
         budget--;
         if (exp_q.size() == 0) break;
      end
      check("batch_drain", exp_q.size(), 0);
      exp_q.delete();
      req = 4'b0000;
      repeat (2) @(negedge clk);
      check("idle_after_batch", int'(busy), 0);
   endtask

   task automatic run_one(input int port, input int m, input int p, input bit pm);
      bm[port] = 7'(m);
      bp[port] = 7'(p);
      penny_mode = pm;
      run_batch(4'(1 << port));
      penny_mode = 1'b0;
   endtask

   initial begin
      int budget;
      int r;
      logic [3:0] mask;
      reset = 1'b0;
      req = 4'b0000;
      req_money = '0;
      req_price = '0;
      for (int i = 0; i < NREQ; i++) begin
         bm[i] = 7'd0;
         bp[i] = 7'd0;
      end
      repeat (3) @(negedge clk);
      check("rst_ack", int'(ack), 0);
      check("rst_err", int'(err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_fsm_start", int'(fsm_start), 0);
      check("rst_gnt_id", int'(gnt_id), 0);
      check("rst_chg", int'({chg_q, chg_d, chg_n, chg_p}), 0);
      check("rst_fsm_money", int'(fsm_money), 0);
      check("rst_fsm_price", int'(fsm_price), 0);
      check("rst_fsm_reset", int'(fsm_reset), 1);
      reset = 1'b1;
      @(negedge clk);
      check("run_fsm_reset", int'(fsm_reset), 0);

      run_one(0, 75, 64, 1'b0);
      run_one(1, 100, 54, 1'b0);
      run_one(3, 55, 63, 1'b0);
      bm[0] = 7'd90; bp[0] = 7'd12;
      bm[2] = 7'd33; bp[2] = 7'd7;
      run_batch(4'b0101);
      bm[0] = 7'd41; bp[0] = 7'd40;
      bm[1] = 7'd60; bp[1] = 7'd35;
      run_batch(4'b0011);
      run_one(2, 50, 50, 1'b0);
      run_one(1, 40, 10, 1'b1);
      run_one(0, 127, 0, 1'b0);
      run_one(3, 0, 1, 1'b0);

      // Reset while the DUT is parked in WAIT with no done coming.
      mock_en = 1'b0;
      bm[2] = 7'd100; bp[2] = 7'd1;
      req_money[14 +: 7] = bm[2];
      req_price[14 +: 7] = bp[2];
      req = 4'b0100;
      budget = 20;
      while (!fsm_start && budget > 0) begin @(negedge clk); budget--; end
      check("rw_start_seen", int'(fsm_start), 1);
      budget = 20;
      while (fsm_start && budget > 0) begin @(negedge clk); budget--; end
      repeat (3) @(negedge clk);
      check("rw_busy_in_wait", int'(busy), 1);
      check("rw_gnt_id", int'(gnt_id), 2);
      reset = 1'b0;
      req = 4'b0000;
      @(negedge clk);
      check("rw_busy", int'(busy), 0);
      check("rw_ack", int'(ack), 0);
      check("rw_err", int'(err), 0);
      check("rw_gnt_id_clr", int'(gnt_id), 0);
      check("rw_fsm_money", int'(fsm_money), 0);
      check("rw_fsm_start", int'(fsm_start), 0);
      check("rw_fsm_reset", int'(fsm_reset), 1);
      reset = 1'b1;
      mock_en = 1'b1;
      ptr_model = 0;
      @(negedge clk);
      check("rw_fsm_reset_rel", int'(fsm_reset), 0);

      for (int b = 0; b < 20; b++) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < NREQ; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
               bp[i] = 7'($urandom_range(1, 127));
               bm[i] = 7'($urandom_range(0, int'(bp[i]) - 1));
            end else if (r == 3) begin
               bp[i] = 7'($urandom_range(0, 127));
               bm[i] = bp[i];
            end else begin
               bp[i] = 7'($urandom_range(0, 127));
               bm[i] = 7'($urandom_range(int'(bp[i]), 127));
            end
         end
         penny_mode = ($urandom_range(0, 4) == 0);
         run_batch(mask);
         penny_mode = 1'b0;
      end

      check("start_pulses", seen_starts, exp_starts);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
